// File: rtl/gb_timer_pkg.sv
// -----------------------------------------------------------------------------
// gb_timer_pkg : register offsets, TAC tap mapping and FSM encoding
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package gb_timer_pkg;

  localparam logic [1:0] OFS_DIV  = 2'd0;
  localparam logic [1:0] OFS_TIMA = 2'd1;
  localparam logic [1:0] OFS_TMA  = 2'd2;
  localparam logic [1:0] OFS_TAC  = 2'd3;

  localparam logic [1:0] OVF_WAIT_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_OVF_WAIT = 2'd1,
    ST_RELOAD   = 2'd2
  } state_e;

  // div_cnt bit that clocks TIMA for each TAC[1:0] setting
  function automatic logic [3:0] tap_index(input logic [1:0] sel);
    case (sel)
      2'b00:   tap_index = 4'd9;
      2'b01:   tap_index = 4'd3;
      2'b10:   tap_index = 4'd5;
      default: tap_index = 4'd7;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gb_timer_if.sv
// -----------------------------------------------------------------------------
// gb_timer_if : CPU-side bus of the timer block
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface gb_timer_if;
  logic [15:0] address_bus_in;
  logic [7:0]  data_in;
  logic        mem_we;
  logic [7:0]  data_out;
  logic        timer_sel;
  logic        timer_int_req;

  modport master (
    output address_bus_in, data_in, mem_we,
    input  data_out, timer_sel, timer_int_req
  );

  modport slave (
    input  address_bus_in, data_in, mem_we,
    output data_out, timer_sel, timer_int_req
  );
endinterface

`default_nettype wire

// File: rtl/gb_timer_tick_sel.sv
// -----------------------------------------------------------------------------
// timer_tick_sel : TAC tap mux, enable and registered falling-edge detector
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module timer_tick_sel
  import gb_timer_pkg::*;
(
  input  wire logic        clk_i,
  input  wire logic        rst_ni,
  input  wire logic [15:0] div_cnt_i,
  input  wire logic [2:0]  tac_i,
  output logic             tick_fall_o
);

  logic tick_in;
  logic tick_q;

  // Any source of a 1->0 drop counts, including DIV clears and TAC rewrites
  assign tick_in     = tac_i[2] & div_cnt_i[tap_index(tac_i[1:0])];
  assign tick_fall_o = tick_q & ~tick_in;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gb_timer.sv
// -----------------------------------------------------------------------------
// gb_timer : DMG-compatible DIV/TIMA/TMA/TAC timer with delayed overflow reload
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gb_timer
  import gb_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  wire logic core_clk,
  input  wire logic reset_n,
  gb_timer_if.slave bus
);

  logic [15:0] div_q, div_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [1:0]  wait_q, wait_d;
  state_e      state_q, state_d;

  logic [15:0] w_rel;
  logic [1:0]  w_ofs;
  logic        w_sel;
  logic        w_wr_div, w_wr_tima, w_wr_tma, w_wr_tac;
  logic        w_tick_fall;
  logic        w_int_req;
  logic [7:0]  w_rdata;

  // Unsigned wrap makes addresses below BASE_ADDR land far outside 0..3
  assign w_rel     = bus.address_bus_in - BASE_ADDR;
  assign w_sel     = (w_rel[15:2] == 14'd0);
  assign w_ofs     = w_rel[1:0];
  assign w_wr_div  = bus.mem_we & w_sel & (w_ofs == OFS_DIV);
  assign w_wr_tima = bus.mem_we & w_sel & (w_ofs == OFS_TIMA);
  assign w_wr_tma  = bus.mem_we & w_sel & (w_ofs == OFS_TMA);
  assign w_wr_tac  = bus.mem_we & w_sel & (w_ofs == OFS_TAC);

  assign div_d = w_wr_div ? 16'd0 : div_q + 16'd1;
  assign tac_d = w_wr_tac ? bus.data_in[2:0] : tac_q;
  assign tma_d = w_wr_tma ? bus.data_in : tma_q;

  timer_tick_sel u_tick_sel (
    .clk_i       (core_clk),
    .rst_ni      (reset_n),
    .div_cnt_i   (div_q),
    .tac_i       (tac_q),
    .tick_fall_o (w_tick_fall)
  );

  always_comb begin
    state_d   = state_q;
    tima_d    = tima_q;
    wait_d    = wait_q;
    w_int_req = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (w_wr_tima) begin
          tima_d = bus.data_in;
        end else if (w_tick_fall) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            wait_d  = 2'd0;
            state_d = ST_OVF_WAIT;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      ST_OVF_WAIT: begin
        if (w_wr_tima) begin
          tima_d  = bus.data_in;
          state_d = ST_RUN;
        end else if (wait_q == OVF_WAIT_LAST) begin
          state_d = ST_RELOAD;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_RELOAD: begin
        // tma_d already carries a same-cycle TMA write; TIMA writes lose here
        tima_d    = tma_d;
        w_int_req = 1'b1;
        state_d   = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (!reset_n) begin
      div_q   <= 16'd0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'd0;
      wait_q  <= 2'd0;
      state_q <= ST_RUN;
    end else begin
      div_q   <= div_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      wait_q  <= wait_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    w_rdata = 8'h00;
    if (w_sel) begin
      case (w_ofs)
        OFS_DIV:  w_rdata = div_q[15:8];
        OFS_TIMA: w_rdata = tima_q;
        OFS_TMA:  w_rdata = tma_q;
        default:  w_rdata = {5'b11111, tac_q};
      endcase
    end
  end

  assign bus.data_out      = w_rdata;
  assign bus.timer_sel     = w_sel;
  assign bus.timer_int_req = w_int_req;

endmodule

`default_nettype wire

// File: tb/tb_gb_timer.sv
// -----------------------------------------------------------------------------
// tb_gb_timer : directed self-checking bench for gb_timer
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_gb_timer;
  import gb_timer_pkg::*;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

  logic core_clk = 1'b0;
  logic reset_n  = 1'b0;
  int   errs     = 0;
  int   checks   = 0;
  int   int_cnt  = 0;

  gb_timer_if bus_if ();

  gb_timer #(.BASE_ADDR(16'hFF04)) dut (
    .core_clk (core_clk),
    .reset_n  (reset_n),
    .bus      (bus_if)
  );

  always #5 core_clk = ~core_clk;

  always @(negedge core_clk) begin
    if (bus_if.timer_int_req === 1'b1) int_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus_if.address_bus_in = addr;
    bus_if.data_in        = data;
    bus_if.mem_we         = 1'b1;
    @(negedge core_clk);
    bus_if.mem_we         = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus_if.address_bus_in = addr;
    #1;
    chk(tag, {8'h00, bus_if.data_out}, {8'h00, exp});
  endtask

  task automatic chk_int(input string tag, input logic exp);
    #1;
    chk(tag, {15'd0, bus_if.timer_int_req}, {15'd0, exp});
  endtask

  task automatic chk_icnt(input string tag, input int exp);
    #1;
    chk(tag, 16'(int_cnt), 16'(exp));
  endtask

  // Reloads TIMA with FF right after a DIV clear; overflow then lands 16 edges later
  task automatic arm_overflow();
    wr(A_DIV, 8'h00);
    wr(A_TIMA, 8'hFF);
  endtask

  initial begin
    bus_if.address_bus_in = 16'h0000;
    bus_if.data_in        = 8'h00;
    bus_if.mem_we         = 1'b0;

    // Reset values
    step(3);
    rd("rst_div",  A_DIV,  8'h00);
    rd("rst_tima", A_TIMA, 8'h00);
    rd("rst_tma",  A_TMA,  8'h00);
    rd("rst_tac",  A_TAC,  8'hF8);
    chk_int("rst_int", 1'b0);
    reset_n = 1'b1;

    // Address decode boundaries
    bus_if.address_bus_in = 16'hFF03; #1;
    chk("sel_below", {15'd0, bus_if.timer_sel}, 16'd0);
    chk("data_below", {8'h00, bus_if.data_out}, 16'h0000);
    bus_if.address_bus_in = 16'hFF08; #1;
    chk("sel_above", {15'd0, bus_if.timer_sel}, 16'd0);
    chk("data_above", {8'h00, bus_if.data_out}, 16'h0000);
    bus_if.address_bus_in = A_TAC; #1;
    chk("sel_tac", {15'd0, bus_if.timer_sel}, 16'd1);

    // 512 idle cycles
    step(512);
    rd("idle_div",  A_DIV,  8'h02);
    rd("idle_tima", A_TIMA, 8'h00);
    rd("idle_tac",  A_TAC,  8'hF8);
    chk_icnt("idle_noint", 0);

    // Overflow with reload from TMA
    wr(A_DIV, 8'h00);
    wr(A_TAC, 8'h05);
    rd("tac_rd", A_TAC, 8'hFD);
    wr(A_TMA, 8'hAB);
    wr(A_TIMA, 8'hFE);
    step(14);
    rd("inc_ff", A_TIMA, 8'hFF);
    step(16);
    rd("ovf_zero", A_TIMA, 8'h00);
    chk("ovf_state", {14'd0, dut.state_q}, {14'd0, ST_OVF_WAIT});
    step(3);
    rd("ovf_wait4", A_TIMA, 8'h00);
    chk_int("ovf_noint", 1'b0);
    step(1);
    chk_int("reload_int", 1'b1);
    step(1);
    rd("reload_tima", A_TIMA, 8'hAB);
    chk_int("reload_int_end", 1'b0);
    chk_icnt("reload_pulses", 1);

    // TIMA write on the 2nd OVF_WAIT cycle cancels the reload
    arm_overflow();
    step(16);
    rd("c_ovf", A_TIMA, 8'h00);
    step(1);
    wr(A_TIMA, 8'h33);
    rd("c_tima", A_TIMA, 8'h33);
    step(6);
    rd("c_keep", A_TIMA, 8'h33);
    chk_icnt("c_noint", 1);
    chk("c_state", {14'd0, dut.state_q}, {14'd0, ST_RUN});

    // div_cnt[3] is high here, so clearing DIV produces exactly one tick
    wr(A_DIV, 8'h00);
    rd("d_div0", A_DIV, 8'h00);
    rd("d_before", A_TIMA, 8'h33);
    step(1);
    rd("d_inc", A_TIMA, 8'h34);
    step(2);
    rd("d_once", A_TIMA, 8'h34);
    rd("d_div1", A_DIV, 8'h00);

    // TMA write in the RELOAD cycle
    arm_overflow();
    step(20);
    chk_int("t_reload", 1'b1);
    wr(A_TMA, 8'h77);
    rd("t_tima", A_TIMA, 8'h77);
    rd("t_tma", A_TMA, 8'h77);

    // TIMA write in the RELOAD cycle is ignored
    arm_overflow();
    step(20);
    chk_int("i_reload", 1'b1);
    wr(A_TIMA, 8'h10);
    rd("i_tima", A_TIMA, 8'h77);
    chk_icnt("i_pulses", 3);

    // Reset during OVF_WAIT
    arm_overflow();
    step(17);
    chk("r_state", {14'd0, dut.state_q}, {14'd0, ST_OVF_WAIT});
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    rd("r_div",  A_DIV,  8'h00);
    rd("r_tima", A_TIMA, 8'h00);
    rd("r_tma",  A_TMA,  8'h00);
    rd("r_tac",  A_TAC,  8'hF8);
    step(10);
    rd("r_tima_late", A_TIMA, 8'h00);
    chk_icnt("r_noint", 3);
    chk("r_run", {14'd0, dut.state_q}, {14'd0, ST_RUN});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gb_timer.md
GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'hFF04, address of DIV; TIMA, TMA and TAC follow at +1, +2 and +3.
REQ-002 SHALL have port core_clk  input  1  single system clock; all logic rising-edge on it.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port address_bus_in  input  16  CPU address.
REQ-005 SHALL have port data_in  input  8  CPU write data.
REQ-006 SHALL have port mem_we  input  1  write strobe; one-cycle write to the addressed register.
REQ-007 SHALL have port data_out  output  8  read data, combinational from address_bus_in and the current registers.
REQ-008 SHALL have port timer_sel  output  1  high when address_bus_in is in BASE_ADDR..BASE_ADDR+3.
REQ-009 SHALL have port timer_int_req  output  1  one-cycle pulse to the memory interrupt-flag logic.

Function
REQ-010 SHALL keep a 16-bit div_cnt that increments by 1 every core_clk and wraps 16'hFFFF->0.
REQ-011 SHALL return div_cnt[15:8] on a DIV read; any DIV write SHALL clear div_cnt to 0 on the next edge.
REQ-012 SHALL select the tap bit from TAC[1:0]: 00->div_cnt[9], 01->div_cnt[3], 10->div_cnt[5], 11->div_cnt[7].
REQ-013 SHALL form tick_in = TAC[2] AND tap, register it, and increment TIMA on each 1->0 transition of tick_in.
REQ-014 SHALL count falling edges of tick_in that are caused by a DIV write or a TAC write, as real DMG hardware does.
REQ-015 SHALL give a CPU write to TIMA priority over a same-cycle increment.
REQ-016 SHALL implement state machine RUN, OVF_WAIT, RELOAD for overflow handling.
REQ-017 SHALL move from RUN to OVF_WAIT when TIMA increments from 8'hFF to 8'h00; TIMA SHALL read 8'h00 while in OVF_WAIT.
REQ-018 SHALL stay in OVF_WAIT for exactly 4 cycles, then enter RELOAD for 1 cycle.
REQ-019 SHALL, in RELOAD, load TIMA with TMA, assert timer_int_req for that single cycle, and then return to RUN.
REQ-020 SHALL cancel the reload and the interrupt on a TIMA write during OVF_WAIT; the written value is kept and the state returns to RUN.
REQ-021 SHALL ignore a TIMA write in the RELOAD cycle, so the TMA value wins.
REQ-022 SHALL make a TMA write in the RELOAD cycle load the new TMA value into TIMA in that same cycle.
REQ-023 SHALL suppress TIMA increments while in OVF_WAIT or RELOAD.
REQ-024 SHALL read TAC as {5'b11111, TAC[2:0]} and ignore TAC[7:3] on writes.
REQ-025 SHALL drive data_out to 8'h00 and timer_sel to 0 for addresses outside the timer range.

Reset
REQ-026 SHALL, with reset_n low at a clock edge, clear div_cnt, TIMA, TMA, TAC and the registered tick_in to 0, set the state to RUN, and drive timer_int_req to 0.
REQ-027 SHALL make reset mid-OVF_WAIT abandon the pending reload and interrupt.
REQ-028 SHALL give DIV, TIMA and TMA read values of 8'h00 after reset, and a TAC read value of 8'hF8.

Structure
REQ-029 SHALL place the register offsets, the TAC tap-select mapping and the state encoding in shared package gb_timer_pkg.
REQ-030 SHALL contain one sub-module, timer_tick_sel: the tap mux, the enable and the registered falling-edge detector; the rest stays flat.

Verification
REQ-031 SHALL cover: reset, then 512 cycles idle -> DIV reads 8'h02, TIMA 8'h00, TAC 8'hF8, timer_int_req never high.
REQ-032 SHALL cover: TAC=8'h05, TMA=8'hAB, TIMA=8'hFE -> after 32 cycles TIMA=8'h00, 4 cycles later TIMA=8'hAB with a 1-cycle timer_int_req.
REQ-033 SHALL cover: overflow, then a TIMA=8'h33 write on the 2nd OVF_WAIT cycle -> TIMA stays 8'h33, no timer_int_req, state RUN.
REQ-034 SHALL cover: TAC=8'h05 with div_cnt[3]=1, then a DIV write -> TIMA increments by exactly 1 and DIV reads 8'h00.
REQ-035 SHALL cover: a TMA=8'h77 write exactly on the RELOAD cycle -> TIMA=8'h77; a TIMA=8'h10 write on the RELOAD cycle -> ignored.
REQ-036 SHALL cover: reset_n low during OVF_WAIT -> all registers 0, no timer_int_req pulse afterwards.
